// File: rtl/dividerunit.sv
// Sequential FP32 divider: 25-step restoring mantissa division, one quotient bit per clock,
// with a start/done handshake. Hidden bit always 1, truncation, NaN = {sign, FF, 000001}.
module dividerunit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataR
);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM
  } state_t;

  state_t       state_q, state_d;
  logic         sign_q, sign_d;
  logic [7:0]   ea_q, ea_d;
  logic [7:0]   eb_q, eb_d;
  logic [23:0]  mb_q, mb_d;
  logic [24:0]  r_q, r_d;
  logic [24:0]  q_q, q_d;
  logic [4:0]   count_q, count_d;
  logic         special_q, special_d;
  logic [31:0]  spec_res_q, spec_res_d;
  logic         done_q, done_d;
  logic [31:0]  data_r_q, data_r_d;

  // Operand classification on the live inputs; only used in IDLE when start is sampled.
  logic        sign_in;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic        is_special;
  logic [31:0] special_res;

  always_comb begin
    sign_in     = dataA[31] ^ dataB[31];
    exp_a       = dataA[30:23];
    exp_b       = dataB[30:23];
    frac_a      = dataA[22:0];
    frac_b      = dataB[22:0];
    nan_a       = (exp_a == 8'hFF) && (frac_a != '0);
    nan_b       = (exp_b == 8'hFF) && (frac_b != '0);
    inf_a       = (exp_a == 8'hFF) && (frac_a == '0);
    inf_b       = (exp_b == 8'hFF) && (frac_b == '0);
    zero_a      = (dataA[30:0] == '0);
    zero_b      = (dataB[30:0] == '0);
    is_special  = 1'b1;
    special_res = '0;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      special_res = {sign_in, 8'hFF, 23'h000001};
    end else if (inf_a || zero_b) begin
      special_res = {sign_in, 8'hFF, 23'h000000};
    end else if (zero_a || inf_b) begin
      special_res = {sign_in, 8'h00, 23'h000000};
    end else begin
      is_special = 1'b0;
    end
  end

  // Normalisation of the finished quotient.
  logic signed [9:0] exp_raw, exp_adj;
  logic [22:0]       frac_n;
  logic [31:0]       norm_res;

  always_comb begin
    exp_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
    if (q_q[24]) begin
      frac_n  = q_q[23:1];
      exp_adj = exp_raw;
    end else begin
      frac_n  = q_q[22:0];
      exp_adj = exp_raw - 10'sd1;
    end
    if (exp_adj >= 10'sd255) begin
      norm_res = {sign_q, 8'hFF, 23'h000000};
    end else if (exp_adj <= 10'sd0) begin
      norm_res = {sign_q, 8'h00, 23'h000000};
    end else begin
      norm_res = {sign_q, exp_adj[7:0], frac_n};
    end
  end

  // One restoring step: remainder never exceeds 24 bits before the shift.
  logic        q_bit;
  logic [24:0] r_diff;

  always_comb begin
    r_diff = r_q - {1'b0, mb_q};
    q_bit  = (r_q >= {1'b0, mb_q});
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    mb_d       = mb_q;
    r_d        = r_q;
    q_d        = q_q;
    count_d    = count_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    done_d     = 1'b0;
    data_r_d   = data_r_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = sign_in;
          ea_d   = exp_a;
          eb_d   = exp_b;
          mb_d   = {1'b1, frac_b};
          if (is_special) begin
            special_d  = 1'b1;
            spec_res_d = special_res;
            state_d    = NORM;
          end else begin
            special_d = 1'b0;
            r_d       = {2'b01, frac_a};
            q_d       = '0;
            count_d   = '0;
            state_d   = DIV;
          end
        end
      end
      DIV: begin
        if (q_bit) begin
          r_d = {r_diff[23:0], 1'b0};
        end else begin
          r_d = {r_q[23:0], 1'b0};
        end
        q_d     = {q_q[23:0], q_bit};
        count_d = count_q + 5'd1;
        if (count_q == 5'd24) begin
          state_d = NORM;
        end
      end
      NORM: begin
        data_r_d = special_q ? spec_res_q : norm_res;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      ea_q       <= '0;
      eb_q       <= '0;
      mb_q       <= '0;
      r_q        <= '0;
      q_q        <= '0;
      count_q    <= '0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
      done_q     <= 1'b0;
      data_r_q   <= '0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      ea_q       <= ea_d;
      eb_q       <= eb_d;
      mb_q       <= mb_d;
      r_q        <= r_d;
      q_q        <= q_d;
      count_q    <= count_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      done_q     <= done_d;
      data_r_q   <= data_r_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign dataR = data_r_q;

endmodule

// File: tb/tb_dividerunit.sv
// Scoreboard bench for dividerunit: stimulus pushes expected result and completion cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_dividerunit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic [31:0] dataR;

  dividerunit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .dataA (dataA),
    .dataB (dataB),
    .busy  (busy),
    .done  (done),
    .dataR (dataR)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: plain integer division of the significands, then pack. Returns {special, result}.
  function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    longint      ma, mb, q;
    logic [22:0] fa, fb, fr;
    bit          na, nb, ia, ib, za, zb;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    za = (a[30:0] == 0);
    zb = (b[30:0] == 0);
    if (na || nb || (za && zb) || (ia && ib)) return {1'b1, s, 8'hFF, 23'h1};
    if (ia || zb) return {1'b1, s, 8'hFF, 23'h0};
    if (za || ib) return {1'b1, s, 8'h00, 23'h0};
    ma = longint'(fa) + (64'd1 << 23);
    mb = longint'(fb) + (64'd1 << 23);
    q  = (ma << 24) / mb;
    e  = ea - eb + 127;
    if (q >= (64'd1 << 24)) begin
      fr = 23'((q >> 1) & 64'h7FFFFF);
    end else begin
      fr = 23'(q & 64'h7FFFFF);
      e  = e - 1;
    end
    if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
    if (e <= 0) return {1'b0, s, 8'h00, 23'h0};
    return {1'b0, s, 8'(e), fr};
  endfunction

  // Called at a negedge right before the edge that samples start.
  function automatic void push_exp(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    exp_t        e;
    r     = ref_div(a, b);
    e.res = r[31:0];
    e.cyc = cyc + (r[32] ? 1 : 26) + 1;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: got done with dataR=0x%08h expected no done (cyc=%0d)", dataR, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dataR", dataR, e.res);
        check("done_cycle", 32'(cyc), 32'(e.cyc));
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    dataA = a;
    dataB = b;
    start = 1'b1;
    push_exp(a, b);
    @(negedge clk);
    start = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int          k;
    v = $urandom;
    k = int'($urandom_range(0, 11));
    case (k)
      0: v[30:0] = '0;
      1: v[30:0] = {8'hFF, 23'h0};
      2: begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      3: v[30:23] = 8'h00;
      4: v[30:23] = 8'($urandom_range(0, 1) ? $urandom_range(1, 4) : $urandom_range(250, 254));
      default: v[30:23] = 8'($urandom_range(90, 165));
    endcase
    return v;
  endfunction

  logic [31:0] da[11] = '{32'h40C00000, 32'hC0F00000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                          32'h7F800000, 32'h40000000, 32'h7F000000, 32'h00800000, 32'h7FC00000,
                          32'h00000001};
  logic [31:0] db[11] = '{32'h40000000, 32'h40200000, 32'h40400000, 32'h00000000, 32'h80000000,
                          32'h7F800000, 32'hFF800000, 32'h00800000, 32'h7F000000, 32'h3F800000,
                          32'h3F800000};

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    dataA = '0;
    dataB = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_dataR", dataR, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 6.0/2.0 with busy window
    k = cyc;
    issue(32'h40C00000, 32'h40000000);
    check("busy_k1", {31'd0, busy}, 32'd1);
    while (cyc < k + 26) @(negedge clk);
    check("busy_k25", {31'd0, busy}, 32'd1);
    check("done_early", {31'd0, done}, 32'd0);
    wait_done();

    foreach (da[i]) begin
      issue(da[i], db[i]);
      wait_done();
    end

    // start during busy is ignored; dataR holds afterwards
    k = cyc;
    issue(32'h40C00000, 32'h40000000);
    repeat (4) @(negedge clk);
    dataA = 32'h3F800000;
    dataB = 32'h40400000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    check("dataR_held", dataR, 32'h40400000);

    // reset mid-operation
    k = cyc;
    issue(32'h3F800000, 32'h40400000);
    while (cyc < k + 10) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_dataR", dataR, 32'd0);
    repeat (30) @(negedge clk);

    // reset and start on the same edge
    reset = 1'b1;
    start = 1'b1;
    dataA = 32'h40C00000;
    dataB = 32'h40000000;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("reset_wins_busy", {31'd0, busy}, 32'd0);
    repeat (30) @(negedge clk);

    // back-to-back with start held high
    dataA = 32'h40C00000;
    dataB = 32'h40000000;
    start = 1'b1;
    push_exp(dataA, dataB);
    k = 0;
    @(negedge clk);
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    dataA = 32'h3F800000;
    dataB = 32'h40400000;
    push_exp(dataA, dataB);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // randomized operands
    for (int i = 0; i < 200; i++) begin
      issue(rand_fp(), rand_fp());
      wait_done();
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

endmodule
